// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS fetch slice.
//   - Fetch FSM state encoding (legacy 2-bit codes).
//   - Instruction field widths.
//   - sext_imm(): sign-extends a 16-bit immediate to a full word.
package mips_pkg;

  localparam int OPCODE_W  = 6;
  localparam int IMM_W     = 16;
  localparam int JTARGET_W = 26;
  localparam int WORD_W    = 32;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  function automatic logic [WORD_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: bundles the fetch unit's control inputs, the I-mem
// read bus and the decode-side outputs.
//   master : fetch unit side (drives read_address and decode outputs)
//   slave  : environment side (drives redirects, stall, instruction_in)
interface mips_fetch_unit_if;
  import mips_pkg::*;

  logic                 stall;
  logic                 branch_taken;
  logic [IMM_W-1:0]     branch_offset;
  logic                 jump;
  logic [JTARGET_W-1:0] jump_target;
  logic                 jr;
  logic [WORD_W-1:0]    jr_target;
  logic [WORD_W-1:0]    instruction_in;
  logic [WORD_W-1:0]    read_address;
  logic [WORD_W-1:0]    instr_out;
  logic [WORD_W-1:0]    pc_out;
  logic [WORD_W-1:0]    pc_plus1;
  logic                 instr_valid;
  logic                 halted;
  logic                 addr_error;
  logic [WORD_W-1:0]    instr_count;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, jr, jr_target,
           instruction_in,
    output read_address, instr_out, pc_out, pc_plus1, instr_valid, halted,
           addr_error, instr_count
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, jr, jr_target,
           instruction_in,
    input  read_address, instr_out, pc_out, pc_plus1, instr_valid, halted,
           addr_error, instr_count
  );

endinterface

// File: rtl/mips_next_pc.sv
// mips_next_pc: combinational next-PC resolution.
//   pc                   current word PC
//   branch_taken/offset  pc_plus1-relative branch
//   jump/jump_target     region jump, upper bits taken from pc_plus1
//   jr/jr_target         absolute register-indirect target
//   pc_plus1             pc + 1
//   next_pc              priority-selected target: jr > jump > branch > seq
//   halt_match           winning redirect is a jump back onto pc itself
//   out_of_range         next_pc lies outside 0..IMEM_DEPTH-1
module mips_next_pc
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256
) (
  input  logic [WORD_W-1:0]    pc,
  input  logic                 branch_taken,
  input  logic [IMM_W-1:0]     branch_offset,
  input  logic                 jump,
  input  logic [JTARGET_W-1:0] jump_target,
  input  logic                 jr,
  input  logic [WORD_W-1:0]    jr_target,
  output logic [WORD_W-1:0]    pc_plus1,
  output logic [WORD_W-1:0]    next_pc,
  output logic                 halt_match,
  output logic                 out_of_range
);

  logic [WORD_W-1:0] br_tgt;
  logic [WORD_W-1:0] j_tgt;

  assign pc_plus1 = pc + WORD_W'(1);
  assign br_tgt   = pc_plus1 + sext_imm(branch_offset);
  assign j_tgt    = {pc_plus1[WORD_W-1:JTARGET_W], jump_target};

  always_comb begin
    next_pc = pc_plus1;
    if (jr)                next_pc = jr_target;
    else if (jump)         next_pc = j_tgt;
    else if (branch_taken) next_pc = br_tgt;
  end

  // Only a jump that actually wins priority can be a self-loop halt.
  assign halt_match   = jump && !jr && (j_tgt == pc);
  assign out_of_range = next_pc >= WORD_W'(IMEM_DEPTH);

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: owns the PC, drives the I-mem read address and forwards
// the returned instruction to decode with PC context.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         mips_fetch_unit_if.master (redirects, stall, I-mem bus,
//               decode outputs, status flags, retired-instruction count)
// FSM: BOOT (one idle cycle after reset) -> RUN -> HALTED | FAULT (reset exit).
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'd0,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  mips_fetch_unit_if.master bus
);

  logic [1:0]        state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] cnt;
  logic [WORD_W-1:0] pc_plus1;
  logic [WORD_W-1:0] next_pc;
  logic              halt_match;
  logic              out_of_range;
  logic              run;

  mips_next_pc #(.IMEM_DEPTH(IMEM_DEPTH)) u_next_pc (
    .pc            (pc),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .jr            (bus.jr),
    .jr_target     (bus.jr_target),
    .pc_plus1      (pc_plus1),
    .next_pc       (next_pc),
    .halt_match    (halt_match),
    .out_of_range  (out_of_range)
  );

  assign run = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= PC_RESET;
      cnt   <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (!bus.stall) begin
            cnt <= cnt + WORD_W'(1);
            // A faulting target is never loaded; fault outranks halt.
            if (out_of_range)    state <= ST_FAULT;
            else if (halt_match) state <= ST_HALTED;
            else                 pc    <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction path is combinational from read_address, zero latency.
  assign bus.read_address = pc;
  assign bus.pc_out       = pc;
  assign bus.pc_plus1     = pc_plus1;
  assign bus.instr_valid  = run;
  assign bus.instr_out    = run ? bus.instruction_in : '0;
  assign bus.halted       = (state == ST_HALTED);
  assign bus.addr_error   = (state == ST_FAULT);
  assign bus.instr_count  = cnt;

endmodule
